sn_network_core: RTL and testbench

- Synchronous spiking-neuron network of P_NUM_NEURONS integrate-and-fire neurons.
- Neurons 1..P_NUM_INPUTS are input neurons, driven by external currents. The last P_NUM_OUTPUTS neurons are the outputs. Neurons in between are hidden.
- Each neuron is configured through a per-neuron register file: a constant current, a step (hold) length, and P_TABLE_NUM_ROWS pairs of (source index, weight).
- A network controller runs a programmed number of evaluation periods (one period = one clock) and pulses done when finished.

---
 rtl/sn_network_core.sv | 214 +++++++++++++++++++++
 tb/tb_sn_network_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sn_network_core.sv
// Integrate-and-fire spiking network with a run controller that steps the network once per clock.
// Optional build macro SN_OUT_SPIKE_CNT_EN adds per-output-neuron spike rising-edge counters.
module sn_network_core #(
  parameter int P_NUM_NEURONS       = 21,
  parameter int P_NUM_OUTPUTS       = 3,
  parameter int P_NUM_INPUTS        = 9,
  parameter int P_DFLT_CNTR_VAL     = 40,
  parameter int P_TABLE_NUM_ROWS    = 4,
  parameter int P_TABLE_WEIGHT_BW   = 9,
  parameter int P_NEUR_CURRENT_BW   = 9,
  parameter int P_MAX_NUM_PERIODS   = 2000,
  parameter int P_NEUR_STEP_CNTR_BW = 7,
  parameter int P_NEUR_THRESH       = 256,
  localparam int MSB_BW = $clog2(P_NUM_NEURONS + 1),
  localparam int LSB_BW = $clog2(2 * P_TABLE_NUM_ROWS + 2),
  localparam int PER_BW = $clog2(P_MAX_NUM_PERIODS + 1)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           io_nc_num_per_wen,
  input  logic [PER_BW-1:0]                              io_nc_num_per_d,
  input  logic [P_NUM_INPUTS:1][P_NEUR_CURRENT_BW-1:0]   io_net_inputs,
  input  logic                                           io_nc_start,
  input  logic                                           io_we,
  input  logic [MSB_BW+LSB_BW-1:0]                       io_waddr,
  input  logic [P_NEUR_CURRENT_BW-1:0]                   io_wdata,
`ifdef SN_OUT_SPIKE_CNT_EN
  output logic [P_NUM_OUTPUTS-1:0][PER_BW-1:0]           nc_io_out_cnts,
`endif
  output logic                                           nc_io_done
);

  localparam int CW = P_NEUR_CURRENT_BW;
  localparam int WW = P_TABLE_WEIGHT_BW;
  localparam int SW = P_NEUR_STEP_CNTR_BW;
  localparam int NR = P_TABLE_NUM_ROWS;
  localparam int IW = CW + $clog2(P_TABLE_NUM_ROWS + 2);
  localparam int VW = CW + 4;
  localparam logic [LSB_BW-1:0]    REG_MAX = LSB_BW'(2 * NR + 1);
  localparam logic signed [VW:0]   V_MAX   = (VW+1)'((2 ** (VW - 1)) - 1);
  localparam logic signed [VW-1:0] V_THR   = VW'(P_NEUR_THRESH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (P_NUM_INPUTS + P_NUM_OUTPUTS > P_NUM_NEURONS) begin : g_bad_cfg
    $error("input and output neuron ranges overlap");
  end

  // Clamp membrane potential to [0, signed max of VW bits]
  function automatic logic signed [VW-1:0] sat_v(input logic signed [VW:0] s);
    if (s[VW]) return '0;
    if (s > V_MAX) return V_MAX[VW-1:0];
    return s[VW-1:0];
  endfunction

  logic signed [CW-1:0] r_const [1:P_NUM_NEURONS];
  logic [SW-1:0]        r_step  [1:P_NUM_NEURONS];
  logic [CW-1:0]        r_idx   [1:P_NUM_NEURONS][NR];
  logic signed [WW-1:0] r_wgt   [1:P_NUM_NEURONS][NR];
  logic [MSB_BW-1:0]    w_wn;
  logic [LSB_BW-1:0]    w_wr;

  assign w_wn = io_waddr[MSB_BW+LSB_BW-1:LSB_BW];
  assign w_wr = io_waddr[LSB_BW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 1; n <= P_NUM_NEURONS; n++) begin
        r_const[n] <= '0;
        r_step[n]  <= SW'(P_DFLT_CNTR_VAL);
        for (int r = 0; r < NR; r++) begin
          r_idx[n][r] <= '0;
          r_wgt[n][r] <= '0;
        end
      end
    end else if (io_we && (w_wr <= REG_MAX)) begin
      for (int n = 1; n <= P_NUM_NEURONS; n++) begin
        if (w_wn == MSB_BW'(n)) begin
          if (w_wr == LSB_BW'(0)) r_const[n] <= io_wdata;
          if (w_wr == LSB_BW'(1)) r_step[n] <= io_wdata[SW-1:0];
          for (int r = 0; r < NR; r++) begin
            if (w_wr == LSB_BW'(2 + 2 * r)) r_idx[n][r] <= io_wdata;
            if (w_wr == LSB_BW'(3 + 2 * r)) r_wgt[n][r] <= io_wdata[WW-1:0];
          end
        end
      end
    end
  end

  logic              r_state;
  logic [PER_BW-1:0] r_num_per;
  logic [PER_BW-1:0] r_run_len;
  logic [PER_BW-1:0] r_per_cnt;
  logic              r_done;
  logic              w_start;
  logic              w_upd;
  logic              w_last;

  assign w_start = (r_state == S_IDLE) && io_nc_start;
  assign w_upd   = (r_state == S_RUN) && (r_per_cnt != r_run_len);
  assign w_last  = (r_state == S_RUN) && (r_per_cnt == r_run_len);

  // The run length is latched at start so num_per writes mid-run only affect the next run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_num_per <= '0;
      r_run_len <= '0;
      r_per_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      if (io_nc_num_per_wen) r_num_per <= io_nc_num_per_d;
      r_done <= w_last;
      if (w_start) begin
        r_state   <= S_RUN;
        r_run_len <= r_num_per;
        r_per_cnt <= '0;
      end else if (w_last) begin
        r_state <= S_IDLE;
      end else if (w_upd) begin
        r_per_cnt <= r_per_cnt + 1'b1;
      end
    end
  end

  assign nc_io_done = r_done;

  logic signed [VW-1:0] r_v        [1:P_NUM_NEURONS];
  logic [SW-1:0]        r_hold     [1:P_NUM_NEURONS];
  logic signed [VW-1:0] w_v_nxt    [1:P_NUM_NEURONS];
  logic [SW-1:0]        w_hold_nxt [1:P_NUM_NEURONS];
  logic [CW-1:0]        w_ext      [1:P_NUM_NEURONS];
  logic [P_NUM_NEURONS:0] w_spike;
  logic signed [IW-1:0] w_cur;
  logic signed [VW:0]   w_sum;
  logic signed [VW-1:0] w_vt;

  always_comb begin
    w_spike = '0;
    for (int n = 1; n <= P_NUM_NEURONS; n++) w_spike[n] = (r_hold[n] != '0);
  end

  always_comb begin
    for (int n = 1; n <= P_NUM_NEURONS; n++) w_ext[n] = '0;
    for (int n = 1; n <= P_NUM_INPUTS; n++) w_ext[n] = io_net_inputs[n];
  end

  // Row sources outside 1..P_NUM_NEURONS never contribute; bit 0 of w_spike is tied low
  always_comb begin
    w_cur = '0;
    w_sum = '0;
    w_vt  = '0;
    for (int n = 1; n <= P_NUM_NEURONS; n++) begin
      w_cur = IW'(r_const[n]) + $signed(IW'(w_ext[n]));
      for (int r = 0; r < NR; r++) begin
        if ((r_idx[n][r] <= CW'(P_NUM_NEURONS)) && w_spike[r_idx[n][r][MSB_BW-1:0]])
          w_cur = w_cur + IW'(r_wgt[n][r]);
      end
      w_sum = (VW+1)'(r_v[n]) + (VW+1)'(w_cur);
      w_vt  = sat_v(w_sum);
      if (r_hold[n] != '0) begin
        w_hold_nxt[n] = r_hold[n] - 1'b1;
        w_v_nxt[n]    = '0;
      end else if (w_vt >= V_THR) begin
        w_hold_nxt[n] = (r_step[n] == '0) ? SW'(1) : r_step[n];
        w_v_nxt[n]    = '0;
      end else begin
        w_hold_nxt[n] = '0;
        w_v_nxt[n]    = w_vt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 1; n <= P_NUM_NEURONS; n++) begin
        r_v[n]    <= '0;
        r_hold[n] <= '0;
      end
    end else if (w_start) begin
      for (int n = 1; n <= P_NUM_NEURONS; n++) begin
        r_v[n]    <= '0;
        r_hold[n] <= '0;
      end
    end else if (w_upd) begin
      for (int n = 1; n <= P_NUM_NEURONS; n++) begin
        r_v[n]    <= w_v_nxt[n];
        r_hold[n] <= w_hold_nxt[n];
      end
    end
  end

`ifdef SN_OUT_SPIKE_CNT_EN
  localparam int OBASE = P_NUM_NEURONS - P_NUM_OUTPUTS + 1;
  logic [P_NUM_OUTPUTS-1:0][PER_BW-1:0] r_out_cnt;

  // A rising spike edge is a hold counter leaving zero on this update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else if (w_start) begin
      r_out_cnt <= '0;
    end else if (w_upd) begin
      for (int o = 0; o < P_NUM_OUTPUTS; o++) begin
        if ((r_hold[OBASE+o] == '0) && (w_hold_nxt[OBASE+o] != '0))
          r_out_cnt[o] <= r_out_cnt[o] + 1'b1;
      end
    end
  end

  assign nc_io_out_cnts = r_out_cnt;
`endif

endmodule

// File: tb/tb_sn_network_core.sv
// Bench for sn_network_core: latency table, directed firing scenarios and randomized
// configurations compared period by period against an integer reference network.
module tb_sn_network_core;
  localparam int N = 21, NI = 9, NR = 4, PER_BW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, io_nc_num_per_wen, io_nc_start, io_we;
  logic [PER_BW-1:0] io_nc_num_per_d;
  logic [NI:1][8:0] io_net_inputs;
  logic [8:0] io_waddr, io_wdata;
  logic nc_io_done;
`ifdef SN_OUT_SPIKE_CNT_EN
  logic [2:0][PER_BW-1:0] nc_io_out_cnts;
`endif

  sn_network_core dut (
    .clk(clk), .rst(rst),
    .io_nc_num_per_wen(io_nc_num_per_wen), .io_nc_num_per_d(io_nc_num_per_d),
    .io_net_inputs(io_net_inputs), .io_nc_start(io_nc_start),
    .io_we(io_we), .io_waddr(io_waddr), .io_wdata(io_wdata),
`ifdef SN_OUT_SPIKE_CNT_EN
    .nc_io_out_cnts(nc_io_out_cnts),
`endif
    .nc_io_done(nc_io_done)
  );

  int n_chk = 0, n_fail = 0;
  int m_const[1:N], m_step[1:N], m_idx[1:N][NR], m_wgt[1:N][NR], m_v[1:N], m_hold[1:N];
  int m_in[1:NI];
  int fst[1:N], len1[1:N], cnt[1:N], vsnap[1:N];
  bit in1[1:N];

  typedef struct { int ld; int mid_np; bit mid_st; int exp_len; } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sx9(input int d);
    return (d & 256) ? (d & 511) - 512 : (d & 511);
  endfunction

  task automatic model_reset_cfg();
    for (int n = 1; n <= N; n++) begin
      m_const[n] = 0; m_step[n] = 40; m_v[n] = 0; m_hold[n] = 0;
      for (int r = 0; r < NR; r++) begin m_idx[n][r] = 0; m_wgt[n][r] = 0; end
    end
  endtask

  task automatic cfg_write(input int n, input int rg, input int d);
    @(negedge clk);
    io_we = 1'b1; io_waddr = {5'(n), 4'(rg)}; io_wdata = 9'(d);
    @(posedge clk); #1 io_we = 1'b0;
    if (n >= 1 && n <= N && rg <= 2 * NR + 1) begin
      if (rg == 0) m_const[n] = sx9(d);
      else if (rg == 1) m_step[n] = d & 127;
      else if (rg % 2 == 0) m_idx[n][(rg - 2) / 2] = d & 511;
      else m_wgt[n][(rg - 3) / 2] = sx9(d);
    end
  endtask

  task automatic load_np(input int v);
    @(negedge clk); io_nc_num_per_wen = 1'b1; io_nc_num_per_d = PER_BW'(v);
    @(negedge clk); io_nc_num_per_wen = 1'b0;
  endtask

  task automatic set_in(input int n, input int v);
    m_in[n] = v; io_net_inputs[n] = 9'(v);
  endtask

  // One period of the network, straight from the neuron rules
  task automatic model_step();
    int sp[1:N];
    int cur, vt;
    for (int n = 1; n <= N; n++) sp[n] = (m_hold[n] != 0);
    for (int n = 1; n <= N; n++) begin
      cur = m_const[n];
      for (int r = 0; r < NR; r++)
        if (m_idx[n][r] >= 1 && m_idx[n][r] <= N && sp[m_idx[n][r]] == 1) cur += m_wgt[n][r];
      if (n <= NI) cur += m_in[n];
      if (m_hold[n] > 0) begin
        m_hold[n]--; m_v[n] = 0;
      end else begin
        vt = m_v[n] + cur;
        if (vt < 0) vt = 0;
        if (vt > 4095) vt = 4095;
        if (vt >= 256) begin m_v[n] = 0; m_hold[n] = (m_step[n] == 0) ? 1 : m_step[n]; end
        else m_v[n] = vt;
      end
    end
  endtask

  task automatic run(input int np, input int mid_np, input bit mid_st);
    logic [N:1] expv;
    int bn;
    for (int n = 1; n <= N; n++) begin
      fst[n] = 0; len1[n] = 0; cnt[n] = 0; in1[n] = 0; vsnap[n] = 0; m_v[n] = 0; m_hold[n] = 0;
    end
    @(negedge clk); io_nc_start = 1'b1;
    @(negedge clk); io_nc_start = 1'b0;
    for (int j = 1; j <= np; j++) begin
      if (j == 2) begin
        if (mid_np >= 0) begin io_nc_num_per_wen = 1'b1; io_nc_num_per_d = PER_BW'(mid_np); end
        if (mid_st) io_nc_start = 1'b1;
      end
      @(negedge clk);
      io_nc_num_per_wen = 1'b0; io_nc_start = 1'b0;
      model_step();
      for (int n = 1; n <= N; n++) expv[n] = (m_hold[n] != 0);
      chk($sformatf("spikes@%0d", j), dut.w_spike[N:1], expv);
      bn = 1;
      for (int n = N; n >= 1; n--) if (int'(dut.r_v[n]) != m_v[n]) bn = n;
      chk($sformatf("vmem[%0d]@%0d", bn, j), dut.r_v[bn], m_v[bn]);
      chk($sformatf("done_early@%0d", j), nc_io_done, 0);
      for (int n = 1; n <= N; n++) begin
        if (j == 30) vsnap[n] = int'(dut.r_v[n]);
        if (dut.w_spike[n]) begin
          cnt[n]++;
          if (fst[n] == 0) begin fst[n] = j; in1[n] = 1'b1; end
          if (in1[n]) len1[n]++;
        end else if (fst[n] != 0) in1[n] = 1'b0;
      end
    end
    @(negedge clk); chk("done_pulse", nc_io_done, 1);
    @(negedge clk); chk("done_single", nc_io_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, rg, d;
    rst = 1'b1; io_nc_num_per_wen = 1'b0; io_nc_num_per_d = '0; io_nc_start = 1'b0;
    io_we = 1'b0; io_waddr = '0; io_wdata = '0;
    for (int i = 1; i <= NI; i++) set_in(i, 0);
    model_reset_cfg();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", nc_io_done, 0);
    chk("rst_spikes", dut.w_spike, 0);
    chk("rst_step11", dut.r_step[11], 40);
    chk("rst_num_per", dut.r_num_per, 0);

    tbl[0] = '{5, -1, 1'b0, 5};
    tbl[1] = '{0, -1, 1'b0, 0};
    tbl[2] = '{1, -1, 1'b0, 1};
    tbl[3] = '{7, 3, 1'b1, 7};
    tbl[4] = '{-1, -1, 1'b0, 3};
    tbl[5] = '{2, -1, 1'b0, 2};
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].ld >= 0) load_np(tbl[t].ld);
      run(tbl[t].exp_len, tbl[t].mid_np, tbl[t].mid_st);
    end

    // Input-driven firing and the default hold length
    set_in(1, 16);
    load_np(60);
    run(60, -1, 1'b0);
    chk("n1_first_fire", fst[1], 16);
    chk("n1_hold_len", len1[1], 40);

    // Excitatory synapse from neuron 1 into hidden neuron 10
    cfg_write(10, 2, 1);
    cfg_write(10, 3, 10);
    load_np(100);
    run(100, -1, 1'b0);
    chk("n10_first_fire", fst[10], 42);

    // Inhibitory synapse: potential clamps at zero, never fires
    cfg_write(11, 0, 4);
    cfg_write(11, 2, 1);
    cfg_write(11, 3, (-20) & 511);
    run(100, -1, 1'b0);
    chk("n11_clamp_v30", vsnap[11], 0);
    chk("n11_no_fire", cnt[11], 0);

    // Ignored writes, then a long step length
    cfg_write(0, 0, 100);
    cfg_write(0, 1, 5);
    cfg_write(11, 15, 77);
    cfg_write(11, 10, 77);
    cfg_write(22, 0, 100);
    cfg_write(31, 1, 3);
    cfg_write(11, 2, 0);
    cfg_write(11, 0, 128);
    cfg_write(11, 1, 120);
    set_in(1, 0);
    begin
      int bn = 1;
      for (int i = N; i >= 1; i--)
        if (int'(dut.r_const[i]) != m_const[i] || int'(dut.r_step[i]) != m_step[i]) bn = i;
      chk($sformatf("cfg_const[%0d]", bn), dut.r_const[bn], m_const[bn]);
      chk($sformatf("cfg_step[%0d]", bn), dut.r_step[bn], m_step[bn]);
    end
    load_np(130);
    run(130, -1, 1'b0);
    chk("n11_first_fire", fst[11], 2);
    chk("n11_hold_len", len1[11], 120);

    // Randomized configurations against the reference network
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 120; w++) begin
        n = $urandom_range(0, 31); rg = $urandom_range(0, 15); d = $urandom_range(0, 511);
        if (rg >= 2 && rg % 2 == 0) d = $urandom_range(0, 23);
        if (rg == 1) d = $urandom_range(0, 20);
        if (rg == 0) d = sx9(d) / 4 & 511;
        cfg_write(n, rg, d);
      end
      for (int i = 1; i <= NI; i++) set_in(i, $urandom_range(0, 40));
      d = $urandom_range(20, 80);
      load_np(d);
      run(d, -1, 1'b0);
    end

    // Asynchronous reset in the middle of a long run
    set_in(1, 16);
    load_np(1500);
    @(negedge clk); io_nc_start = 1'b1;
    @(negedge clk); io_nc_start = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_rst_n1_spike", dut.w_spike[1], 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_spikes", dut.w_spike, 0);
    chk("async_rst_step11", dut.r_step[11], 40);
    @(negedge clk); rst = 1'b0;
    model_reset_cfg();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("no_done_after_rst@%0d", c), nc_io_done, 0);
    end
    load_np(1500);
    run(1500, -1, 1'b0);
    chk("restart_n1_first_fire", fst[1], 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
